// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: iterative 32x32 multiplier sequencing an external combinational adder
// Ports: clk, reset (async, active-high), start/a/b request, busy/done/product status,
//        add_a/add_b/add_sel drive the shared adder, add_sum/add_c32 return its result.
// Build option: SEQ_MULT_SIGNED_EN selects radix-2 Booth (signed); default is unsigned shift-add.
module seq_mult_ctrl #(
    parameter logic [2:0] ADD_SEL = 3'b010,
    parameter logic [2:0] SUB_SEL = 3'b110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic [2:0]  add_sel,
    input  logic [31:0] add_sum,
    input  logic        add_c32
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [63:0] p_q, p_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] step;
    logic        calc, sub_step;
    assign calc    = state_q == CALC;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign product = p_q;
    assign add_a   = p_q[63:32];
    assign add_b   = m_q;
    assign add_sel = sub_step ? SUB_SEL : ADD_SEL;
`ifdef SEQ_MULT_SIGNED_EN
    logic        q_q, q_d, add_step, s;
    logic [31:0] nv;
    assign add_step = calc && !p_q[0] && q_q;
    assign sub_step = calc && p_q[0] && !q_q;
    always_comb begin
        nv   = (add_step || sub_step) ? add_sum : p_q[63:32];
        // s is bit 32 of the exact 33-bit signed sum, so overflow of the
        // 32-bit adder (e.g. M = 0x80000000) does not corrupt the sign.
        s    = add_step ? p_q[63] ^ m_q[31] ^ add_c32 :
               sub_step ? p_q[63] ^ ~m_q[31] ^ add_c32 : p_q[63];
        step = {s, nv, p_q[31:1]};
        q_d  = calc ? p_q[0] : (state_q == IDLE && start) ? 1'b0 : q_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= 1'b0;
        else       q_q <= q_d;
`else
    assign sub_step = 1'b0;
    assign step     = p_q[0] ? {add_c32, add_sum, p_q[31:1]} : {1'b0, p_q[63:1]};
`endif
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CALC;
                m_d     = a;
                p_d     = {32'd0, b};
                cnt_d   = 6'd0;
            end
            CALC: begin
                p_d     = step;
                cnt_d   = cnt_q + 6'd1;
                state_d = (cnt_q == 6'd31) ? DONE : CALC;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            m_q     <= 32'd0;
            p_q     <= 64'd0;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: randomized self-checking bench with a behavioural multiply model
module tb_seq_mult_ctrl;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    logic        clk = 0, reset = 0, start = 0, go = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done, add_c32;
    logic [63:0] product;
    logic [31:0] add_a, add_b, add_sum;
    logic [2:0]  add_sel;
    int          pass_n = 0, total_n = 0;
    seq_mult_ctrl #(.ADD_SEL(ADD), .SUB_SEL(SUB)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .add_a(add_a), .add_b(add_b), .add_sel(add_sel),
        .add_sum(add_sum), .add_c32(add_c32)
    );
    always #5 clk = ~clk;
    always_comb
        {add_c32, add_sum} = (add_sel == SUB) ? {1'b0, add_a} + {1'b0, ~add_b} + 33'd1
                                              : {1'b0, add_a} + {1'b0, add_b};
    function automatic logic [63:0] mul(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        return {{32{x[31]}}, x} * {{32{y[31]}}, y};
`else
        return {32'd0, x} * {32'd0, y};
`endif
    endfunction
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
        else pass_n++;
    endtask
    // phase 0 = idle, 1..32 = multiply steps, 33 = result cycle
    int          phase = 0;
    logic [63:0] exp_prod = 0, exp_fin = 0;
    logic [31:0] exp_m = 0, b_l = 0;
    always @(posedge clk or posedge reset)
        if (reset) begin
            phase <= 0; exp_prod <= 0; exp_m <= 0; b_l <= 0;
        end else if (phase == 0) begin
            if (start) begin
                phase <= 1; exp_m <= a; b_l <= b; exp_fin <= mul(a, b);
            end
        end else if (phase == 32) begin
            phase <= 33; exp_prod <= exp_fin;
        end else if (phase == 33) phase <= 0;
        else phase <= phase + 1;
    function automatic logic [2:0] exp_sel();
        logic [32:0] ext;
        ext = {b_l, 1'b0};
`ifdef SEQ_MULT_SIGNED_EN
        if (phase >= 1 && phase <= 32) begin
            if (ext[phase] && !ext[phase-1]) return SUB;
        end
`endif
        return ADD;
    endfunction
    always @(negedge clk)
        if (go) begin
            chk("busy", {63'd0, busy}, {63'd0, phase != 0});
            chk("done", {63'd0, done}, {63'd0, phase == 33});
            chk("add_b", {32'd0, add_b}, {32'd0, exp_m});
            chk("add_sel", {61'd0, add_sel}, {61'd0, exp_sel()});
            if (phase == 0 || phase == 33) begin
                chk("product", product, exp_prod);
                chk("add_a", {32'd0, add_a}, {32'd0, exp_prod[63:32]});
            end
        end
    task automatic run(input logic [31:0] x, input logic [31:0] y, input bit hold,
                       output logic [63:0] res);
        int n = 0;
        @(negedge clk); a = x; b = y; start = 1;
        @(negedge clk);
        if (!hold) begin start = 0; a = $urandom; b = $urandom; end
        while (!done && n < 40) begin
            if (hold) begin a = $urandom; b = $urandom; end
            @(negedge clk); n++;
        end
        chk("latency", 64'(n), 64'd32);
        start = 0;
        res = product;
    endtask
    initial begin
        logic [63:0] r;
        logic [31:0] x, y;
        #2 reset = 1;
        go = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_product", product, 64'd0);
        run(32'd3, 32'd5, 0, r);
        chk("p_3x5", r, 64'hF);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 0, r);
`ifdef SEQ_MULT_SIGNED_EN
        chk("p_m1xm1", r, 64'd1);
        run(32'hFFFFFFFD, 32'd7, 0, r);
        chk("p_m3x7", r, 64'hFFFFFFFFFFFFFFEB);
        run(32'h80000000, 32'h80000000, 0, r);
        chk("p_minxmin", r, 64'h4000000000000000);
`else
        chk("p_maxxmax", r, 64'hFFFFFFFE00000001);
`endif
        run(32'd9, 32'd11, 1, r);
        chk("p_hold", r, 64'd99);
        run(32'd0, 32'h12345678, 0, r);
        chk("p_zero", r, 64'd0);
        @(negedge clk); a = $urandom; b = $urandom; start = 1;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_product", product, 64'd0);
        chk("arst_add_a", {32'd0, add_a}, 64'd0);
        chk("arst_add_b", {32'd0, add_b}, 64'd0);
        chk("arst_add_sel", {61'd0, add_sel}, {61'd0, ADD});
        @(negedge clk); reset = 0;
        run(32'd6, 32'd7, 0, r);
        chk("p_6x7", r, 64'h2A);
        for (int i = 0; i < 16; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: x = 32'h80000000;
                1: y = 32'hFFFFFFFF;
                2: x = 32'd0;
                default: ;
            endcase
            run(x, y, 1'($urandom_range(0, 1)), r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
